// File: rtl/arm_multicycle_core.sv
// Multicycle ARM-subset core: ADD/SUB/AND/ORR, LDR/STR with immediate offset, B.
// A single memory port is shared by instruction fetch and data accesses and uses
// a req/ready handshake. NZCV flags are stored and gate conditional execution.
module arm_multicycle_core #(
  parameter logic [31:0] RESET_PC  = 32'h0,
  parameter int          ADDR_W    = 32,
  parameter bit          COND_EXEC = 1'b1
) (
  input  logic              clk,
  input  logic              Reset,
  output logic              mem_req,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [31:0]       mem_wdata,
  input  logic [31:0]       mem_rdata,
  input  logic              mem_ready,
  output logic [31:0]       PC,
  output logic [3:0]        Flags,
  output logic [3:0]        state
);

  typedef enum logic [3:0] {
    FETCH  = 4'd0,
    DECODE = 4'd1,
    MEMADR = 4'd2,
    MEMRD  = 4'd3,
    MEMWB  = 4'd4,
    MEMWR  = 4'd5,
    EXECR  = 4'd6,
    EXECI  = 4'd7,
    ALUWB  = 4'd8,
    BRANCH = 4'd9
  } statetype;

  statetype cur, nxt;

  logic [31:0] ir;
  logic [31:0] rn_val, rm_val, rd_val;
  logic [31:0] alu_out, data_q, addr_q;
  logic [3:0]  alu_flags_q;
  logic        alu_wr_q;
  // Slot 15 is never read or written: R15 is the PC.
  logic [31:0] rf [0:15];

  logic [31:0]        pc_plus4;
  logic [31:0]        rn_rd, rm_rd, rd_rd;
  logic [31:0]        src_b;
  logic [31:0]        alu_res;
  logic               alu_c, alu_v, alu_ok;
  logic               cond_ok;
  logic signed [31:0] br_off;

  // Evaluates an ARM condition code against stored NZCV; 1111 behaves as AL.
  function automatic logic cond_holds(input logic [3:0] c, input logic [3:0] f);
    logic n, z, cf, v;
    {n, z, cf, v} = f;
    case (c)
      4'b0000: cond_holds = z;
      4'b0001: cond_holds = !z;
      4'b0010: cond_holds = cf;
      4'b0011: cond_holds = !cf;
      4'b0100: cond_holds = n;
      4'b0101: cond_holds = !n;
      4'b0110: cond_holds = v;
      4'b0111: cond_holds = !v;
      4'b1000: cond_holds = cf && !z;
      4'b1001: cond_holds = !cf || z;
      4'b1010: cond_holds = (n == v);
      4'b1011: cond_holds = (n != v);
      4'b1100: cond_holds = !z && (n == v);
      4'b1101: cond_holds = z || (n != v);
      default: cond_holds = 1'b1;
    endcase
  endfunction

  // R15 reads see the fetch address + 8 (PC already advanced by 4 in FETCH).
  assign pc_plus4 = PC + 32'd4;
  assign rn_rd    = (ir[19:16] == 4'd15) ? pc_plus4 : rf[ir[19:16]];
  assign rm_rd    = (ir[3:0]   == 4'd15) ? pc_plus4 : rf[ir[3:0]];
  assign rd_rd    = (ir[15:12] == 4'd15) ? pc_plus4 : rf[ir[15:12]];
  assign cond_ok  = COND_EXEC ? cond_holds(ir[31:28], Flags) : 1'b1;
  assign br_off   = {{6{ir[23]}}, ir[23:0], 2'b00};

  // ALU: operand B is the unshifted Rm or the zero-extended imm8 (rotate ignored).
  always_comb begin
    alu_res = 32'd0;
    alu_c   = 1'b0;
    alu_v   = 1'b0;
    alu_ok  = 1'b1;
    src_b   = (cur == EXECI) ? {24'd0, ir[7:0]} : rm_val;
    case (ir[24:21])
      4'b0100: begin
        {alu_c, alu_res} = {1'b0, rn_val} + {1'b0, src_b};
        alu_v = (rn_val[31] == src_b[31]) && (alu_res[31] != rn_val[31]);
      end
      4'b0010: begin
        {alu_c, alu_res} = {1'b0, rn_val} + {1'b0, ~src_b} + 33'd1;
        alu_v = (rn_val[31] != src_b[31]) && (alu_res[31] != rn_val[31]);
      end
      4'b0000: alu_res = rn_val & src_b;
      4'b1100: alu_res = rn_val | src_b;
      default: alu_ok = 1'b0;
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) cur <= FETCH;
    else        cur <= nxt;
  end

  // Next-state logic and memory-port outputs; req is forced low during reset.
  always_comb begin
    nxt       = cur;
    mem_req   = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = addr_q[ADDR_W-1:0];
    mem_wdata = rd_val;
    case (cur)
      FETCH: begin
        mem_req  = Reset;
        mem_addr = PC[ADDR_W-1:0];
        if (mem_ready) nxt = DECODE;
      end
      DECODE: begin
        if (!cond_ok) nxt = FETCH;
        else begin
          case (ir[27:26])
            2'b00:   nxt = ir[25] ? EXECI : EXECR;
            2'b01:   nxt = MEMADR;
            2'b10:   nxt = BRANCH;
            default: nxt = FETCH;
          endcase
        end
      end
      EXECR, EXECI: nxt = ALUWB;
      ALUWB:        nxt = FETCH;
      MEMADR:       nxt = ir[20] ? MEMRD : MEMWR;
      MEMRD: begin
        mem_req = Reset;
        if (mem_ready) nxt = MEMWB;
      end
      MEMWB: nxt = FETCH;
      MEMWR: begin
        mem_req = Reset;
        mem_we  = Reset;
        if (mem_ready) nxt = FETCH;
      end
      BRANCH:  nxt = FETCH;
      default: nxt = FETCH;
    endcase
  end

  assign state = cur;

  // Datapath registers: PC, IR, register file, flags and inter-state latches.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      PC          <= RESET_PC;
      Flags       <= 4'd0;
      ir          <= 32'd0;
      rn_val      <= 32'd0;
      rm_val      <= 32'd0;
      rd_val      <= 32'd0;
      alu_out     <= 32'd0;
      alu_flags_q <= 4'd0;
      alu_wr_q    <= 1'b0;
      data_q      <= 32'd0;
      addr_q      <= 32'd0;
      for (int i = 0; i < 16; i++) rf[i] <= 32'd0;
    end else begin
      case (cur)
        FETCH: begin
          if (mem_ready) begin
            ir <= mem_rdata;
            PC <= pc_plus4;
          end
        end
        DECODE: begin
          rn_val <= rn_rd;
          rm_val <= rm_rd;
          rd_val <= rd_rd;
        end
        EXECR, EXECI: begin
          alu_out     <= alu_res;
          alu_flags_q <= {alu_res[31], (alu_res == 32'd0), alu_c, alu_v};
          alu_wr_q    <= alu_ok;
        end
        ALUWB: begin
          if (alu_wr_q) begin
            if (ir[15:12] == 4'd15) PC <= alu_out;
            else                    rf[ir[15:12]] <= alu_out;
            if (ir[20]) Flags <= alu_flags_q;
          end
        end
        MEMADR: begin
          addr_q <= ir[23] ? (rn_val + {20'd0, ir[11:0]})
                           : (rn_val - {20'd0, ir[11:0]});
        end
        MEMRD: begin
          if (mem_ready) data_q <= mem_rdata;
        end
        MEMWB: begin
          if (ir[15:12] == 4'd15) PC <= data_q;
          else                    rf[ir[15:12]] <= data_q;
        end
        BRANCH: PC <= pc_plus4 + $unsigned(br_off);
        default: ;
      endcase
    end
  end

endmodule
